// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package loader_pkg;

  // Loader sequencing states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CHK  = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

  // Bytes per instruction word (big-endian lanes)
  localparam int unsigned BYTES_PER_WORD = 4;

  // Default instruction-memory word-address width
  localparam int unsigned DEFAULT_ADDR_W = 8;

endpackage

// File: rtl/byte_packer.sv
// Assembles four stream bytes into one big-endian 32-bit word.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt;
  // Only the first three bytes need storing; the fourth is taken straight
  // from the stream so the word is available on the accepting edge.
  logic [23:0] held;

  // Byte-lane counter and partial-word shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      held <= '0;
    end else if (clear) begin
      cnt  <= '0;
      held <= '0;
    end else if (accept) begin
      cnt  <= cnt + 2'd1;
      held <= {held[15:0], in_byte};
    end
  end

  // Completed word: first byte lands in [31:24], fourth in [7:0]
  always_comb begin
    word       = {held, in_byte};
    word_valid = accept && !clear && (cnt == 2'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: length header, big-endian words,
// trailing XOR checksum, then releases the processor from hold.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 2 ** ADDR_W
) (
  input  logic              ref_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  loader_state_t state;
  logic [31:0]   len;
  logic [31:0]   idx;
  logic [31:0]   checksum;
  logic [31:0]   word;
  logic          word_valid;
  logic          accept;
  logic          load_start;

  // Status outputs decoded only from state
  always_comb begin
    in_ready   = (state == LEN) || (state == DATA) || (state == CHK);
    busy       = in_ready;
    done       = (state == RUN);
    err        = (state == ERR);
    cpu_hold   = (state != RUN);
    accept     = in_valid && in_ready;
    load_start = start && ((state == IDLE) || (state == ERR));
  end

  byte_packer u_packer (
    .clk        (ref_clk),
    .rst_n      (reset),
    .clear      (load_start),
    .accept     (accept),
    .in_byte    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Load sequencer with registered write port, word index and checksum
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      len        <= '0;
      idx        <= '0;
      checksum   <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (start) begin
            state    <= LEN;
            idx      <= '0;
            checksum <= '0;
          end
        end
        LEN: begin
          if (word_valid) begin
            len <= word;
            if ((word == 32'd0) || (word > 32'(MAX_WORDS))) state <= ERR;
            else                                             state <= DATA;
          end
        end
        DATA: begin
          if (word_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= ADDR_W'(BASE_ADDR + idx);
            imem_wdata <= word;
            checksum   <= checksum ^ word;
            idx        <= idx + 32'd1;
            if ((idx + 32'd1) == len) state <= CHK;
          end
        end
        CHK: begin
          if (word_valid) begin
            if (word == checksum) state <= RUN;
            else                  state <= ERR;
          end
        end
        RUN: state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
